piso_framer: RTL and testbench

Parallel-in, serial-out framing stage that sits directly upstream of the SISO shift-register chain. It accepts a WIDTH-bit word on a valid/ready handshake and drives it onto the single-bit serial line as a frame: start bit, data bits LSB first, an optional even-parity bit, and a stop bit. Each bit is held for a programmable number of clock cycles. The line idles high between frames.

---
 rtl/piso_framer.sv | 178 +++++++++++++++++
 tb/tb_piso_framer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/piso_framer.sv
// piso_framer: accepts a WIDTH-bit word on a valid/ready handshake and
// drives it onto a single-bit serial line as a frame:
//   start(0), data LSB first, optional even-parity bit, stop(1).
// Each serial bit is held for BIT_CYCLES clocks. The line idles high.
module piso_framer #(
  parameter int WIDTH      = 8,
  parameter int BIT_CYCLES = 1,
  parameter int PARITY_EN  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             data_out,
  output logic             busy,
  output logic             frame_done
);

  // Cycle counter needs at least one bit even when BIT_CYCLES == 1.
  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int BW = $clog2(WIDTH);

  localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cyc_cnt;
  logic [CW-1:0]    cyc_nxt;
  logic [BW-1:0]    bit_cnt;
  logic [BW-1:0]    bit_nxt;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shift_nxt;
  logic             par_bit;
  logic             par_nxt;
  logic             line_nxt;
  logic             cyc_wrap;
  logic             accept;

  // Even parity: the XOR of all data bits, so the frame's data plus
  // parity bit always carries an even number of ones.
  function automatic logic even_parity(input logic [WIDTH-1:0] word);
    return ^word;
  endfunction

  // Advance the per-bit cycle counter, wrapping at the end of each bit.
  function automatic logic [CW-1:0] cyc_step(input logic [CW-1:0] cnt);
    return (cnt == CYC_LAST) ? '0 : cnt + CW'(1);
  endfunction

  // The last clock of the current serial bit.
  assign cyc_wrap = (cyc_cnt == CYC_LAST);

  // Ready in IDLE, or in the final stop cycle so frames can run back to
  // back; forced low while reset is held.
  assign in_ready = !reset && ((state == IDLE) || ((state == STOP) && cyc_wrap));

  assign accept = in_valid && in_ready;

  assign frame_done = (state == STOP) && cyc_wrap;

  // Next-state, counter and datapath decode for the framing sequence.
  always_comb begin
    state_nxt = state;
    cyc_nxt   = cyc_cnt;
    bit_nxt   = bit_cnt;
    shift_nxt = shift_reg;
    par_nxt   = par_bit;

    if (state != IDLE) begin
      cyc_nxt = cyc_step(cyc_cnt);
    end

    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = START;
          shift_nxt = in_data;
          par_nxt   = even_parity(in_data);
          cyc_nxt   = '0;
          bit_nxt   = '0;
        end
      end

      START: begin
        if (cyc_wrap) begin
          state_nxt = DATA;
          bit_nxt   = '0;
        end
      end

      DATA: begin
        if (cyc_wrap) begin
          shift_nxt = shift_reg >> 1;
          if (bit_cnt == BIT_LAST) begin
            state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
            bit_nxt   = '0;
          end else begin
            bit_nxt = bit_cnt + BW'(1);
          end
        end
      end

      PARITY: begin
        if (cyc_wrap) begin
          state_nxt = STOP;
        end
      end

      STOP: begin
        if (cyc_wrap) begin
          if (accept) begin
            // Back-to-back: the next start bit follows with no idle gap.
            state_nxt = START;
            shift_nxt = in_data;
            par_nxt   = even_parity(in_data);
            cyc_nxt   = '0;
            bit_nxt   = '0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
        cyc_nxt   = '0;
        bit_nxt   = '0;
      end
    endcase
  end

  // Serial level for the coming cycle, taken from the state being entered
  // so data_out can be registered without adding a cycle of latency.
  always_comb begin
    line_nxt = 1'b1;
    case (state_nxt)
      START:   line_nxt = 1'b0;
      DATA:    line_nxt = shift_nxt[0];
      PARITY:  line_nxt = par_nxt;
      default: line_nxt = 1'b1;
    endcase
  end

  // Control registers: state, counters, serial line and busy flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cyc_cnt  <= '0;
      bit_cnt  <= '0;
      data_out <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      cyc_cnt  <= cyc_nxt;
      bit_cnt  <= bit_nxt;
      data_out <= line_nxt;
      busy     <= (state_nxt != IDLE);
    end
  end

  // Data registers: word and parity are only meaningful once a frame has
  // been accepted, so they carry no reset.
  always_ff @(posedge clk) begin
    shift_reg <= shift_nxt;
    par_bit   <= par_nxt;
  end

endmodule

// File: tb/tb_piso_framer.sv
// Bench for piso_framer: two instances (BIT_CYCLES=1 with parity, and
// BIT_CYCLES=4 without) checked every cycle against a line-level model that
// expands each accepted word into its expected per-cycle serial waveform.
module tb_piso_framer;

  localparam int W = 8;
  localparam int QN = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] din   [2];
  logic         vld   [2];
  logic         rdy   [2];
  logic         dout  [2];
  logic         bsy   [2];
  logic         fdone [2];

  always #5 clk = ~clk;

  piso_framer #(.WIDTH(W), .BIT_CYCLES(1), .PARITY_EN(1)) dut_a (
    .clk(clk), .reset(reset), .in_data(din[0]), .in_valid(vld[0]),
    .in_ready(rdy[0]), .data_out(dout[0]), .busy(bsy[0]), .frame_done(fdone[0])
  );

  piso_framer #(.WIDTH(W), .BIT_CYCLES(4), .PARITY_EN(0)) dut_b (
    .clk(clk), .reset(reset), .in_data(din[1]), .in_valid(vld[1]),
    .in_ready(rdy[1]), .data_out(dout[1]), .busy(bsy[1]), .frame_done(fdone[1])
  );

  int total = 0;
  int bad   = 0;

  // Model: remaining expected line levels of the frame(s) in flight;
  // entry 0 is the current cycle. Empty means idle.
  logic         exp_line [2][QN];
  int           exp_len  [2];
  logic         acc      [2];
  // Words waiting to be presented on each input.
  logic [W-1:0] pend     [2][16];
  int           pend_n   [2];
  int           gap_pct = 0;

  function automatic int bc_of(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  function automatic int pe_of(input int i);
    return (i == 0) ? 1 : 0;
  endfunction

  function automatic string nm(input int i, input string s);
    return {(i == 0) ? "a." : "b.", s};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Frame = start 0, data LSB first, parity (XOR of data) if enabled, stop 1,
  // each level repeated bc times.
  task automatic push_frame(input int i, input logic [W-1:0] w);
    int   nb;
    logic v;
    nb = W + 2 + pe_of(i);
    for (int b = 0; b < nb; b++) begin
      if (b == 0)                          v = 1'b0;
      else if (b <= W)                     v = w[b-1];
      else if (pe_of(i) == 1 && b == W+1)  v = ^w;
      else                                 v = 1'b1;
      for (int r = 0; r < bc_of(i); r++) begin
        exp_line[i][exp_len[i]] = v;
        exp_len[i]++;
      end
    end
  endtask

  task automatic pop_line(input int i);
    for (int k = 0; k < QN-1; k++) exp_line[i][k] = exp_line[i][k+1];
    exp_len[i]--;
  endtask

  task automatic add_word(input int i, input logic [W-1:0] w);
    pend[i][pend_n[i]] = w;
    pend_n[i]++;
  endtask

  // One clock: update model at the edge, compare at the falling edge,
  // then drive the next inputs.
  task automatic step();
    logic er;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      er     = !reset && (exp_len[i] <= 1);
      acc[i] = vld[i] && er;
      if (reset) begin
        exp_len[i] = 0;
      end else begin
        if (exp_len[i] > 0) pop_line(i);
        if (acc[i]) push_frame(i, din[i]);
      end
    end
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk(nm(i, "data_out"), dout[i], (exp_len[i] > 0) ? exp_line[i][0] : 1'b1);
      chk(nm(i, "busy"), bsy[i], exp_len[i] > 0);
      chk(nm(i, "frame_done"), fdone[i], exp_len[i] == 1);
      chk(nm(i, "in_ready"), rdy[i], !reset && (exp_len[i] <= 1));
    end
    for (int i = 0; i < 2; i++) begin
      if (acc[i]) vld[i] = 1'b0;
      if (!vld[i] && pend_n[i] > 0 && ($urandom_range(99) >= gap_pct)) begin
        vld[i] = 1'b1;
        din[i] = pend[i][0];
        for (int k = 0; k < 15; k++) pend[i][k] = pend[i][k+1];
        pend_n[i]--;
      end else if (!vld[i]) begin
        din[i] = W'($urandom);
      end
    end
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (!(exp_len[0] == 0 && exp_len[1] == 0 && pend_n[0] == 0 && pend_n[1] == 0
             && !vld[0] && !vld[1]) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) chk("wait_idle_timeout", 1, 0);
  endtask

  logic exp_a5 [11] = '{0,1,0,1,0,0,1,0,1,0,1};
  logic exp_07 [11] = '{0,1,1,1,0,0,0,0,0,1,1};
  logic exp_81 [10] = '{0,1,0,0,0,0,0,0,1,1};

  initial begin
    int n;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      vld[i] = 1'b0; din[i] = '0; exp_len[i] = 0; pend_n[i] = 0; acc[i] = 1'b0;
    end

    // Reset state
    repeat (3) step();
    reset = 1'b0;
    repeat (2) step();

    // Basic frame 0xA5 on A, stretched 0x81 on B, started together.
    add_word(0, 8'hA5);
    add_word(1, 8'h81);
    step();
    for (int k = 0; k < 40; k++) begin
      step();
      if (k < 11) begin
        chk($sformatf("a5.bit%0d", k), dout[0], exp_a5[k]);
        chk($sformatf("a5.busy%0d", k), bsy[0], 1'b1);
        chk($sformatf("a5.done%0d", k), fdone[0], k == 10);
      end
      chk($sformatf("81.bit%0d", k), dout[1], exp_81[k/4]);
      chk($sformatf("81.done%0d", k), fdone[1], k == 39);
    end
    step();
    chk("81.busy_after", bsy[1], 1'b0);

    // Odd parity count: 0x07
    add_word(0, 8'h07);
    step();
    for (int k = 0; k < 11; k++) begin
      step();
      chk($sformatf("07.bit%0d", k), dout[0], exp_07[k]);
    end
    wait_idle(200);

    // Back-to-back: 0x01 then 0x80 with valid held.
    add_word(0, 8'h01); add_word(0, 8'h80);
    add_word(1, 8'h01); add_word(1, 8'h80);
    n = 0;
    step();
    while (!fdone[0] && n < 200) begin step(); n++; end
    if (n >= 200) chk("b2b.done_timeout", 1, 0);
    chk("b2b.ready_last_stop", rdy[0], 1'b1);
    step();
    chk("b2b.start_no_gap", dout[0], 1'b0);
    chk("b2b.busy_no_gap", bsy[0], 1'b1);
    wait_idle(300);

    // Backpressure: 0x55 presented mid-frame.
    add_word(0, 8'h3A);
    add_word(1, 8'h3A);
    repeat (5) step();
    add_word(0, 8'h55);
    add_word(1, 8'h55);
    step();
    chk("bp.held_not_ready", rdy[0], 1'b0);
    wait_idle(300);

    // Reset mid-frame.
    add_word(0, 8'hF0);
    add_word(1, 8'hF0);
    n = 0;
    step();
    while (!acc[0] && n < 50) begin step(); n++; end
    if (n >= 50) chk("rst.accept_timeout", 1, 0);
    repeat (4) step();
    for (int i = 0; i < 2; i++) vld[i] = 1'b0;
    reset = 1'b1;
    step();
    chk("rst.data_out", dout[0], 1'b1);
    chk("rst.busy", bsy[0], 1'b0);
    chk("rst.frame_done", fdone[0], 1'b0);
    chk("rst.b_busy", bsy[1], 1'b0);
    reset = 1'b0;
    step();
    chk("rst.ready_after", rdy[0], 1'b1);
    add_word(0, 8'h3C);
    add_word(1, 8'h3C);
    wait_idle(300);

    // Randomized traffic with gaps, held valid and occasional reset.
    gap_pct = 40;
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < 2; i++)
        if (pend_n[i] < 4 && $urandom_range(9) == 0) add_word(i, W'($urandom));
      reset = ($urandom_range(499) == 0);
      if (c > 3900) gap_pct = 100;
      step();
    end
    reset = 1'b0;
    gap_pct = 0;
    wait_idle(500);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
